// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: op encodings,
// FSM state enum and the product width.
package mul_ctrl_pkg;

  localparam logic [1:0] MUL_OP_W  = 2'b00;
  localparam logic [1:0] MUL_OP_H  = 2'b01;
  localparam logic [1:0] MUL_OP_HU = 2'b10;

  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_S1   = 2'b01,
    ST_S2   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_issue_ctrl.sv
// Sequences one MUL.W/MULH.W/MULH.WU through the external two-stage multiplier.
// Optional build macro MUL_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_src1,
  input  logic [31:0]       req_src2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              mul_signed,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  input  logic [PROD_W-1:0] mul_result,
  output logic              busy
);

  function automatic logic [31:0] sel_word(input logic [1:0] op,
                                           input logic [PROD_W-1:0] prod);
    case (op)
      MUL_OP_H, MUL_OP_HU: sel_word = prod[63:32];
      default:             sel_word = prod[31:0];
    endcase
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_rsp_data;
  logic [31:0]        r_mul_x;
  logic [31:0]        r_mul_y;
  logic               r_mul_signed;
  logic               w_accept;
  logic               w_bypass;

  assign req_ready = ~flush & ((r_state == ST_IDLE) |
                               ((r_state == ST_DONE) & rsp_ready));
  assign w_accept  = req_valid & req_ready;

`ifdef MUL_ZERO_BYPASS_EN
  assign w_bypass = (req_src1 == 32'd0) | (req_src2 == 32'd0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_S1:   w_state_nxt = ST_S2;
      ST_S2:   w_state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Accepts only happen in IDLE or a completing DONE, so this covers both.
    if (w_accept) w_state_nxt = w_bypass ? ST_DONE : ST_S1;
    if (flush)    w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Operands only load on accept, which never occurs in S1/S2, so they stay
  // frozen for the whole multiplier pass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op         <= MUL_OP_W;
      r_tag        <= '0;
      r_rsp_data   <= '0;
      r_mul_x      <= '0;
      r_mul_y      <= '0;
      r_mul_signed <= 1'b0;
    end else if (w_accept) begin
      r_op  <= req_op;
      r_tag <= req_tag;
      if (w_bypass) begin
        r_rsp_data <= '0;
      end else begin
        r_mul_x      <= req_src1;
        r_mul_y      <= req_src2;
        r_mul_signed <= (req_op != MUL_OP_HU);
      end
    end else if (r_state == ST_S2) begin
      r_rsp_data <= sel_word(r_op, mul_result);
    end
  end

  assign rsp_valid  = (r_state == ST_DONE);
  assign rsp_data   = r_rsp_data;
  assign rsp_tag    = r_tag;
  assign mul_x      = r_mul_x;
  assign mul_y      = r_mul_y;
  assign mul_signed = r_mul_signed;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural two-stage multiplier.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        mul_signed;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TAG_W(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .mul_signed (mul_signed),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_result (mul_result),
    .busy       (busy)
  );

  // Multiplier: stage-1 product registered on the shared clock, valid in S2.
  logic [63:0] w_full;
  always_comb begin
    w_full = {{32{mul_signed & mul_x[31]}}, mul_x} *
             {{32{mul_signed & mul_y[31]}}, mul_y};
  end
  always @(posedge clk) mul_result <= w_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Issues one request from IDLE with rsp_ready high; returns response and latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] d,
                        output logic [4:0] t, output int lat);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rsp_data;
    t = rsp_tag;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, mul_x, mul_y, mul_signed, busy} !== '0) begin
      $display("FAIL reset_outputs: rsp_valid=%0b data=%0h tag=%0h x=%0h y=%0h s=%0b busy=%0b",
               rsp_valid, rsp_data, rsp_tag, mul_x, mul_y, mul_signed, busy);
    end else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b expected 1", req_ready);
    else n_pass++;
    flush = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %0b expected 0", req_ready);
    else n_pass++;
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_ops();
    logic [31:0] d; logic [4:0] t; int lat;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, d, t, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL op00_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++;
    if (d !== 32'h0000_0001) $display("FAIL op00_data: got 0x%0h expected 0x1", d); else n_pass++;
    n_checks++;
    if (t !== 5'd3) $display("FAIL op00_tag: got %0d expected 3", t); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL op00_idle_after: busy=%0b expected 0", busy); else n_pass++;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, d, t, lat);
    n_checks++;
    if (d !== 32'h0000_0000) $display("FAIL op01_data: got 0x%0h expected 0x0", d); else n_pass++;

    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, d, t, lat);
    n_checks++;
    if (d !== 32'hFFFF_FFFE) $display("FAIL op10_data: got 0x%0h expected 0xfffffffe", d); else n_pass++;

    run_op(2'b01, 32'h8000_0000, 32'h0000_0002, 5'd6, d, t, lat);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) $display("FAIL op01_neg_data: got 0x%0h expected 0xffffffff", d); else n_pass++;

    run_op(2'b11, 32'h8000_0000, 32'h0000_0002, 5'd7, d, t, lat);
    n_checks++;
    if (d !== 32'h0000_0000) $display("FAIL op11_data: got 0x%0h expected 0x0", d); else n_pass++;
    n_checks++;
    if (t !== 5'd7) $display("FAIL op11_tag: got %0d expected 7", t); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [4:0] t; int lat;
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd9; req_tag = 5'd1;
    rsp_ready = 1'b1;
    @(negedge clk);            // S1
    req_valid = 1'b0;
    @(negedge clk);            // S2
    flush = 1'b1; req_valid = 1'b1; req_src1 = 32'd3; req_tag = 5'd2;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL flush_blocks_req: req_ready=%0b expected 0", req_ready);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) $display("FAIL flush_to_idle: busy=%0b rsp_valid=%0b expected 0 0", busy, rsp_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid} !== 2'b00) $display("FAIL flush_no_rsp: cycle %0d busy=%0b rsp_valid=%0b expected 0 0", i, busy, rsp_valid);
      else n_pass++;
    end
    run_op(2'b00, 32'd7, 32'd6, 5'd9, d, t, lat);
    n_checks++;
    if (d !== 32'd42) $display("FAIL post_flush_data: got %0d expected 42", d); else n_pass++;
    n_checks++;
    if (t !== 5'd9) $display("FAIL post_flush_tag: got %0d expected 9", t); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd3; req_src2 = 32'd5; req_tag = 5'd4;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_src1 = 32'd2; req_src2 = 32'd11; req_tag = 5'd6;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_tag, req_ready} !== {1'b1, 32'd15, 5'd4, 1'b0})
        $display("FAIL stall_hold: cycle %0d valid=%0b data=%0d tag=%0d req_ready=%0b expected 1 15 4 0",
                 i, rsp_valid, rsp_data, rsp_tag, req_ready);
      else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL release_req_ready: got %0b expected 1", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({busy, rsp_valid} !== 2'b10) $display("FAIL overlap_accept: busy=%0b rsp_valid=%0b expected 1 0", busy, rsp_valid);
    else n_pass++;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 3) $display("FAIL overlap_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++;
    if ({rsp_data, rsp_tag} !== {32'd22, 5'd6}) $display("FAIL overlap_result: data=%0d tag=%0d expected 22 6", rsp_data, rsp_tag);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic [4:0] t; int lat;
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'h1234; req_src2 = 32'h55; req_tag = 5'd12;
    rsp_ready = 1'b1;
    @(negedge clk);            // S1
    req_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_tag, mul_x, mul_y, mul_signed, busy} !== '0)
      $display("FAIL async_reset_outputs: valid=%0b data=%0h tag=%0h x=%0h y=%0h s=%0b busy=%0b",
               rsp_valid, rsp_data, rsp_tag, mul_x, mul_y, mul_signed, busy);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 5'd8, d, t, lat);
    n_checks++;
    if (d !== 32'h0000_0001) $display("FAIL post_reset_data: got 0x%0h expected 0x1", d); else n_pass++;
  endtask

  task automatic test_zero();
    logic [31:0] d; logic [4:0] t; int lat;
    run_op(2'b00, 32'd0, 32'd5, 5'd2, d, t, lat);
`ifdef MUL_ZERO_BYPASS_EN
    n_checks++;
    if (lat !== 1) $display("FAIL zero_latency: got %0d expected 1", lat); else n_pass++;
`else
    n_checks++;
    if (lat !== 3) $display("FAIL zero_latency: got %0d expected 3", lat); else n_pass++;
`endif
    n_checks++;
    if ({d, t} !== {32'd0, 5'd2}) $display("FAIL zero_result: data=%0h tag=%0d expected 0 2", d, t);
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_src1 = '0; req_src2 = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_mul_ops();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
